uart_tx_emitter: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_emitter.sv | 92 +++++++++
 tb/tb_uart_tx_emitter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state type and baud-divider helper for the 8N1 UART transmitter.
package uart_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic {
        IDLE,
        SEND
    } uart_state_e;

    // Returns 0 for an unusable configuration so the caller can reject it at elaboration.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                      input int unsigned baud_rate);
        int unsigned clks;
        if (baud_rate == 0) begin
            return 0;
        end
        clks = clk_freq_hz / baud_rate;
        return (clks >= 2) ? clks : 0;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud down-counter: o_tick marks the last cycle of a bit, o_pre_tick the cycle before it.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load || (r_count == '0)) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tick     = (r_count == '0);
    assign o_pre_tick = (r_count == CNT_W'(1));

endmodule

// File: rtl/uart_tx_emitter.sv
// Transmit-only 8N1 UART: one byte per valid/ready handshake, registered TX and ready.
module uart_tx_emitter
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 10_000_000,
    parameter int unsigned baud_rate   = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(clk_freq_hz, baud_rate);
    localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_cfg_check
        $error("uart_tx_emitter: clk_freq_hz / baud_rate must be at least 2");
    end

    uart_state_e                      r_state = IDLE;
    logic                             r_ready = 1'b1;
    logic                             r_tx    = 1'b1;
    logic [3:0]                       r_bit_idx;
    logic [UART_FRAME_BITS-2:0]       r_shift;
    logic                             w_accept;
    logic                             w_tick;
    logic                             w_pre_tick;

    assign w_accept = i_valid && r_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_accept),
        .o_tick    (w_tick),
        .o_pre_tick(w_pre_tick)
    );

    // Ready rises during the stop bit's final cycle so a queued byte starts with no idle gap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_tx      <= 1'b1;
            r_bit_idx <= '0;
            r_shift   <= '1;
        end else if (w_accept) begin
            r_state   <= SEND;
            r_ready   <= 1'b0;
            r_tx      <= 1'b0;
            r_bit_idx <= '0;
            r_shift   <= {1'b1, i_data};
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready   <= 1'b1;
                    r_tx      <= 1'b1;
                    r_bit_idx <= '0;
                end
                SEND: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b1, r_shift[UART_FRAME_BITS-2:1]};
                        end
                    end else if (w_pre_tick && (r_bit_idx == LAST_BIT)) begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_uart_tx = r_tx;

endmodule

// File: tb/tb_uart_tx_emitter.sv
// Self-checking bench for uart_tx_emitter: directed scenarios plus a randomized model run.
module tb_uart_tx_emitter;

    localparam int CPB_A = 10;
    localparam int CPB_B = 104;
    localparam int FRAME = 10;

    logic       clk = 1'b0;
    logic       a_rst = 1'b1, a_valid = 1'b0, a_ready, a_tx;
    logic       b_rst = 1'b1, b_valid = 1'b0, b_ready, b_tx;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_emitter #(
        .clk_freq_hz(10_000_000),
        .baud_rate  (1_000_000)
    ) u_dut_a (
        .i_clk    (clk),
        .i_rst    (a_rst),
        .i_data   (a_data),
        .i_valid  (a_valid),
        .o_ready  (a_ready),
        .o_uart_tx(a_tx)
    );

    uart_tx_emitter #(
        .clk_freq_hz(12_000_000),
        .baud_rate  (115_200)
    ) u_dut_b (
        .i_clk    (clk),
        .i_rst    (b_rst),
        .i_data   (b_data),
        .i_valid  (b_valid),
        .o_ready  (b_ready),
        .o_uart_tx(b_tx)
    );

    // Expected line level n cycles after the acceptance edge: start, D0..D7, stop.
    function automatic logic model_tx(input logic [7:0] d, input int n, input int cpb);
        int b;
        b = n / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Ready is seen high at the edge 10*cpb cycles after acceptance.
    function automatic logic model_ready(input int n, input int cpb);
        return (n >= FRAME * cpb - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            n_cmp++;
            if (a_ready !== 1'b1 || a_tx !== 1'b1 || b_ready !== 1'b1 || b_tx !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: a_ready=%b a_tx=%b b_ready=%b b_tx=%b, want all 1",
                         i, a_ready, a_tx, b_ready, b_tx);
            end
            tick();
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] dec = 8'h00;
        a_data = 8'h61;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_data = 8'($urandom);
        for (int n = 0; n < FRAME * CPB_A; n++) begin
            n_cmp++;
            if (a_tx !== model_tx(8'h61, n, CPB_A) || a_ready !== model_ready(n, CPB_A)) begin
                n_bad++;
                $display("FAIL single_byte n=%0d: tx=%b ready=%b, want tx=%b ready=%b",
                         n, a_tx, a_ready, model_tx(8'h61, n, CPB_A), model_ready(n, CPB_A));
            end
            if (n % CPB_A == CPB_A / 2 && n / CPB_A >= 1 && n / CPB_A <= 8) dec[n/CPB_A-1] = a_tx;
            tick();
        end
        n_cmp++;
        if (a_tx !== 1'b1 || a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_byte_done: tx=%b ready=%b, want 1 1", a_tx, a_ready);
        end
        n_cmp++;
        if (dec !== 8'h61) begin
            n_bad++;
            $display("FAIL single_byte_decode: got %h, want 61", dec);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] dec = 8'h00;
        a_data = 8'h55;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int n = 0; n < FRAME * CPB_A + 20; n++) begin
            logic et, er;
            et = (n < FRAME * CPB_A) ? model_tx(8'h55, n, CPB_A) : 1'b1;
            er = (n < FRAME * CPB_A) ? model_ready(n, CPB_A) : 1'b1;
            n_cmp++;
            if (a_tx !== et || a_ready !== er) begin
                n_bad++;
                $display("FAIL busy_ignore n=%0d: tx=%b ready=%b, want tx=%b ready=%b",
                         n, a_tx, a_ready, et, er);
            end
            if (n % CPB_A == CPB_A / 2 && n / CPB_A >= 1 && n / CPB_A <= 8) dec[n/CPB_A-1] = a_tx;
            a_valid = (n >= 3 && n < 43);
            a_data = 8'hFF;
            tick();
        end
        n_cmp++;
        if (dec !== 8'h55) begin
            n_bad++;
            $display("FAIL busy_ignore_decode: got %h, want 55", dec);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dec0 = 8'h00, dec1 = 8'h00;
        a_data = 8'h0D;
        a_valid = 1'b1;
        tick();
        a_data = 8'h0A;
        for (int n = 0; n < 2 * FRAME * CPB_A; n++) begin
            int m;
            logic [7:0] d;
            m = (n < FRAME * CPB_A) ? n : n - FRAME * CPB_A;
            d = (n < FRAME * CPB_A) ? 8'h0D : 8'h0A;
            n_cmp++;
            if (a_tx !== model_tx(d, m, CPB_A) || a_ready !== model_ready(m, CPB_A)) begin
                n_bad++;
                $display("FAIL back_to_back n=%0d: tx=%b ready=%b, want tx=%b ready=%b",
                         n, a_tx, a_ready, model_tx(d, m, CPB_A), model_ready(m, CPB_A));
            end
            if (m % CPB_A == CPB_A / 2 && m / CPB_A >= 1 && m / CPB_A <= 8) begin
                if (n < FRAME * CPB_A) dec0[m/CPB_A-1] = a_tx;
                else dec1[m/CPB_A-1] = a_tx;
            end
            if (n == FRAME * CPB_A) a_valid = 1'b0;
            tick();
        end
        n_cmp++;
        if (dec0 !== 8'h0D || dec1 !== 8'h0A || a_tx !== 1'b1 || a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back_decode: got %h %h tx=%b ready=%b, want 0d 0a 1 1",
                     dec0, dec1, a_tx, a_ready);
        end
    endtask

    task automatic test_reset_mid();
        a_data = 8'h00;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int n = 0; n <= 35; n++) begin
            n_cmp++;
            if (a_tx !== model_tx(8'h00, n, CPB_A) || a_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_pre n=%0d: tx=%b ready=%b, want tx=%b ready=0",
                         n, a_tx, a_ready, model_tx(8'h00, n, CPB_A));
            end
            if (n < 35) tick();
        end
        // Reset and valid together: reset must win.
        a_rst = 1'b1;
        a_valid = 1'b1;
        a_data = 8'h5A;
        tick();
        a_rst = 1'b0;
        a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (a_tx !== 1'b1 || a_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_mid_idle i=%0d: tx=%b ready=%b, want 1 1", i, a_tx, a_ready);
            end
            tick();
        end
        a_data = 8'hA5;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int n = 0; n < FRAME * CPB_A; n++) begin
            n_cmp++;
            if (a_tx !== model_tx(8'hA5, n, CPB_A) || a_ready !== model_ready(n, CPB_A)) begin
                n_bad++;
                $display("FAIL reset_mid_resend n=%0d: tx=%b ready=%b, want tx=%b ready=%b",
                         n, a_tx, a_ready, model_tx(8'hA5, n, CPB_A), model_ready(n, CPB_A));
            end
            tick();
        end
    endtask

    task automatic test_random();
        int         m_start = 0;
        logic [7:0] m_byte = 8'h00;
        bit         m_active = 1'b0;
        logic       exp_ready = 1'b1;
        logic       exp_tx;
        int         frames = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic       acc;
            logic [7:0] drv;
            drv = 8'($urandom);
            a_valid = ($urandom_range(0, 3) == 0);
            a_data = drv;
            acc = a_valid && exp_ready;
            tick();
            if (acc) begin
                m_active = 1'b1;
                m_start = cyc;
                m_byte = drv;
                frames++;
            end
            if (m_active && (cyc - m_start) >= FRAME * CPB_A) m_active = 1'b0;
            exp_tx = m_active ? model_tx(m_byte, cyc - m_start, CPB_A) : 1'b1;
            exp_ready = m_active ? model_ready(cyc - m_start, CPB_A) : 1'b1;
            n_cmp++;
            if (a_tx !== exp_tx || a_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL random cyc=%0d byte=%h: tx=%b ready=%b, want tx=%b ready=%b",
                         cyc, m_byte, a_tx, a_ready, exp_tx, exp_ready);
            end
        end
        a_valid = 1'b0;
        n_cmp++;
        if (frames < 5) begin
            n_bad++;
            $display("FAIL random_frames: accepted %0d frames, want at least 5", frames);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] dec = 8'h00;
        b_data = 8'h3C;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int n = 0; n < FRAME * CPB_B; n++) begin
            n_cmp++;
            if (b_tx !== model_tx(8'h3C, n, CPB_B) || b_ready !== model_ready(n, CPB_B)) begin
                n_bad++;
                $display("FAIL sweep n=%0d: tx=%b ready=%b, want tx=%b ready=%b",
                         n, b_tx, b_ready, model_tx(8'h3C, n, CPB_B), model_ready(n, CPB_B));
            end
            if (n % CPB_B == CPB_B / 2 && n / CPB_B >= 1 && n / CPB_B <= 8) dec[n/CPB_B-1] = b_tx;
            tick();
        end
        n_cmp++;
        if (dec !== 8'h3C || b_tx !== 1'b1 || b_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_decode: got %h tx=%b ready=%b, want 3c 1 1", dec, b_tx, b_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (FRAME * CPB_A + 2) tick();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
